// File: rtl/mul_div_unit.sv
// Sequential multiply/divide unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle. Optional abort input enabled by MUL_DIV_CANCEL_EN.
module mul_div_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
`ifdef MUL_DIV_CANCEL_EN
  input  logic                    cancel,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [ALU_OP_WIDTH-1:0] OP_MUL  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MULU = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_DIV  = ALU_OP_WIDTH'(10);
  localparam logic [ALU_OP_WIDTH-1:0] OP_DIVU = ALU_OP_WIDTH'(11);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MFHI = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MFLO = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MTHI = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MTLO = ALU_OP_WIDTH'(7);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [N-1:0]    acc_q, acc_d, mq_q, mq_d, opb_q, opb_d, rs_q, rs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic            dbz_q, dbz_d, done_q, done_d, div_by_zero_q, div_by_zero_d;

  logic            cancel_w;
  logic            is_signed_op;
  logic [N-1:0]    a_mag, b_mag, quo_fix, rem_fix;
  logic [N:0]      add_sum, shifted, sub_diff;
  logic [2*N-1:0]  prod_mag, prod_fix;

`ifdef MUL_DIV_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    acc_d         = acc_q;
    mq_d          = mq_q;
    opb_d         = opb_q;
    rs_d          = rs_q;
    cnt_d         = cnt_q;
    is_div_d      = is_div_q;
    neg_d         = neg_q;
    rem_neg_d     = rem_neg_q;
    dbz_d         = dbz_q;
    done_d        = 1'b0;
    div_by_zero_d = 1'b0;

    is_signed_op = (op == OP_MUL) || (op == OP_DIV);
    a_mag        = (is_signed_op && rs[N-1]) ? -rs : rs;
    b_mag        = (is_signed_op && rt[N-1]) ? -rt : rt;

    // acc holds the product high half / partial remainder, mq the multiplier / quotient
    add_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    shifted  = {acc_q, mq_q[N-1]};
    sub_diff = shifted - {1'b0, opb_q};
    prod_mag = {acc_q, mq_q};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = neg_q ? -mq_q : mq_q;
    rem_fix  = rem_neg_q ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL || op == OP_MULU || op == OP_DIV || op == OP_DIVU) begin
            state_d   = RUN;
            cnt_d     = '0;
            acc_d     = '0;
            mq_d      = a_mag;
            opb_d     = b_mag;
            rs_d      = rs;
            is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
            dbz_d     = (rt == '0);
            neg_d     = is_signed_op && (rs[N-1] ^ rt[N-1]);
            rem_neg_d = is_signed_op && rs[N-1];
          end else if (op == OP_MTHI) begin
            hi_d   = rs;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = rs;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!sub_diff[N]) begin
            acc_d = sub_diff[N-1:0];
            mq_d  = {mq_q[N-2:0], 1'b1};
          end else begin
            acc_d = shifted[N-1:0];
            mq_d  = {mq_q[N-2:0], 1'b0};
          end
        end else begin
          {acc_d, mq_d} = {add_sum, mq_q[N-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dbz_q) begin
          lo_d          = '1;
          hi_d          = rs_q;
          div_by_zero_d = 1'b1;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a completion landing in the same cycle
    if (cancel_w && state_q != IDLE) begin
      state_d       = IDLE;
      hi_d          = hi_q;
      lo_d          = lo_q;
      done_d        = 1'b0;
      div_by_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      acc_q         <= '0;
      mq_q          <= '0;
      opb_q         <= '0;
      rs_q          <= '0;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      acc_q         <= acc_d;
      mq_q          <= mq_d;
      opb_q         <= opb_d;
      rs_q          <= rs_d;
      cnt_q         <= cnt_d;
      is_div_q      <= is_div_d;
      neg_q         <= neg_d;
      rem_neg_q     <= rem_neg_d;
      dbz_q         <= dbz_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign result      = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed results.
module tb_mul_div_unit;

  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_MULU = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_DIVU = 5'b01011;
  localparam logic [4:0] OP_MFHI = 5'b00100;
  localparam logic [4:0] OP_MFLO = 5'b00101;
  localparam logic [4:0] OP_MTHI = 5'b00110;
  localparam logic [4:0] OP_MTLO = 5'b00111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [4:0]  op = 5'b0;
  logic [31:0] rs = 32'h0;
  logic [31:0] rt = 32'h0;
  logic        busy, done, div_by_zero;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;
  logic [31:0] pend_hi = 32'h0;
  logic [31:0] pend_lo = 32'h0;
  logic        pend_dbz = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_dbz = 1'b0;
  int          m_left = 0;

  mul_div_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .rs(rs),
    .rt(rt),
`ifdef MUL_DIV_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .result(result),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Architectural result of each op, straight from integer arithmetic
  function automatic void calcOp(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
    longint    sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    h = 32'h0;
    l = 32'h0;
    if (o == OP_MUL) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (o == OP_MULU) begin
      p = {32'h0, a} * {32'h0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'h0) begin
      l = 32'hFFFF_FFFF;
      h = a;
      z = 1'b1;
    end else if (o == OP_DIV) begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction

  // Reference model: an accepted mul/div finishes 33 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_hi = 32'h0; exp_lo = 32'h0;
      exp_done = 1'b0; exp_dbz = 1'b0; m_left = 0;
    end else begin
      exp_done = 1'b0;
      exp_dbz  = 1'b0;
`ifdef MUL_DIV_CANCEL_EN
      if (cancel && m_left > 0) m_left = -1;
`endif
      if (m_left == -1) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_hi = pend_hi; exp_lo = pend_lo;
          exp_done = 1'b1; exp_dbz = pend_dbz;
        end
      end else if (start) begin
        if (op == OP_MUL || op == OP_MULU || op == OP_DIV || op == OP_DIVU) begin
          calcOp(op, rs, rt, pend_hi, pend_lo, pend_dbz);
          m_left = 33;
        end else if (op == OP_MTHI) begin
          exp_hi = rs; exp_done = 1'b1;
        end else if (op == OP_MTLO) begin
          exp_lo = rs; exp_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      checkOutput("cyc_done", {31'b0, done}, {31'b0, exp_done});
      checkOutput("cyc_dbz", {31'b0, div_by_zero}, {31'b0, exp_dbz});
      checkOutput("cyc_hi", hi, exp_hi);
      checkOutput("cyc_lo", lo, exp_lo);
      checkOutput("cyc_result", result, (op == OP_MFHI) ? exp_hi : (op == OP_MFLO) ? exp_lo : 32'h0);
    end
  end

  // Drive one request for a single edge; caller sits just after a rising edge
  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runOp(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    applyStimulus(o, a, b);
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic expectOp(input string name, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int lat, bcnt;
    runOp(o, a, b, lat, bcnt);
    checkOutput({name, "_latency"}, lat, 32'd33);
    checkOutput({name, "_busycycles"}, bcnt, 32'd33);
    checkOutput({name, "_hi"}, hi, eh);
    checkOutput({name, "_lo"}, lo, el);
    checkOutput({name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
  endtask

  task automatic countDone(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    int lat, bcnt, n;
    #23;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_lo", lo, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expectOp("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    expectOp("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    expectOp("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    expectOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    expectOp("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    expectOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    expectOp("divu_zero", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    expectOp("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
    expectOp("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    expectOp("div_neg_divisor", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

    applyStimulus(OP_MTLO, 32'h1234, 32'h0);
    checkOutput("mtlo_done", {31'b0, done}, 32'd1);
    checkOutput("mtlo_busy", {31'b0, busy}, 32'd0);
    op = OP_MFLO; #1;
    checkOutput("mflo_result", result, 32'h1234);
    @(posedge clk); #1;
    applyStimulus(OP_MTHI, 32'hABCD, 32'h0);
    op = OP_MFHI; #1;
    checkOutput("mfhi_result", result, 32'hABCD);

    applyStimulus(5'b00000, 32'd5, 32'd5);
    checkOutput("badop_done", {31'b0, done}, 32'd0);
    checkOutput("badop_busy", {31'b0, busy}, 32'd0);

    applyStimulus(OP_MUL, 32'd6, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    applyStimulus(OP_MULU, 32'd100, 32'd100);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checkOutput("restart_ignored_done", {31'b0, done}, 32'd1);
    checkOutput("restart_ignored_lo", lo, 32'd42);
    checkOutput("restart_ignored_hi", hi, 32'd0);

    applyStimulus(OP_MTHI, 32'h55, 32'h0);
    applyStimulus(OP_MUL, 32'd6, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_hi", hi, 32'h0);
    checkOutput("midrst_lo", lo, 32'h0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    countDone(40, n);
    checkOutput("midrst_no_done", n, 32'd0);

`ifdef MUL_DIV_CANCEL_EN
    cancel = 1'b1;
    applyStimulus(OP_MTLO, 32'h77, 32'h0);
    cancel = 1'b0;
    checkOutput("cancel_idle_done", {31'b0, done}, 32'd1);
    applyStimulus(OP_MULU, 32'd3, 32'd4);
    repeat (11) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checkOutput("cancel_busy", {31'b0, busy}, 32'd0);
    checkOutput("cancel_hi", hi, 32'h0);
    checkOutput("cancel_lo", lo, 32'h77);
    countDone(40, n);
    checkOutput("cancel_no_done", n, 32'd0);
`endif

    expectOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runOp(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    checkOutput("mul_m1_m1_lo", lo, 32'd1);
    checkOutput("mul_m1_m1_hi", hi, 32'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
